rf_op_sequencer: RTL and testbench
==================================

# rf_op_sequencer

Micro-sequencer that executes single register-file operations against the 4 x 4-bit register-file set. It accepts one command at a time through a valid/ready handshake and drives the register-file read addresses, write address, write data and write enable. It captures the read data, computes the result in a small ALU, writes the result back and reports completion with a done pulse, the result and flags. The block sits between the command source (test bench or future control unit) and the register-file set, and is the only writer of that register file.

## Interface
- `WIDTH`, 4, data width of registers, `WRD`, `A`, `B`, `result`
- `AW`, 2, register address width (2^AW registers)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_op`  in  3  opcode
- `cmd_rd`  in  AW  destination register
- `cmd_rs1`  in  AW  source operand 1
- `cmd_rs2`  in  AW  source operand 2
- `cmd_imm`  in  WIDTH  immediate for LDI
- `RA`  out  AW  register-file read address A
- `RB`  out  AW  register-file read address B
- `A`  in  WIDTH  register-file read data A
- `B`  in  WIDTH  register-file read data B
- `RE`  out  1  register-file write enable
- `WR`  out  AW  register-file write address
- `WRD`  out  WIDTH  register-file write data
- `done`  out  1  one-cycle completion pulse
- `result`  out  WIDTH  last computed result, held
- `zero`  out  1  last result == 0
- `carry`  out  1  carry out (ADD) or borrow (SUB)
- `busy`  out  1  command in flight (state != IDLE)

## Operation
- Opcodes:
  - 000 NOP
  - 001 LDI (rd <- imm)
  - 010 MOV (rd <- rs1)
  - 011 ADD (rd <- rs1 + rs2)
  - 100 SUB (rd <- rs1 - rs2)
  - 101 AND
  - 110 OR
  - 111 XOR
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE: on accept (`cmd_valid & cmd_ready`), go to READ for MOV/ALU ops, to WRITE for LDI, and stay in IDLE for NOP.
  - READ always goes to EXEC.
  - EXEC always goes to WRITE.
  - WRITE always goes to IDLE.
- All `cmd_*` fields are latched at accept. Input changes after accept are ignored.
- `RA`/`RB` carry the latched rs1/rs2 during READ and EXEC, and are 0 otherwise.
- `A`/`B` are sampled at the end of EXEC. This tolerates combinational or 1-cycle registered reads.
- In WRITE only: `RE`=1, `WR`=rd, `WRD`=result. Outside WRITE these three outputs are 0.
- Arithmetic is WIDTH-bit, wrap-around.
  - ADD: `carry` = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: `carry` = 1 iff rs1 < rs2 (unsigned borrow).
- Flag update:
  - `zero` and `result` are updated by LDI, MOV and ALU ops.
  - `carry` is updated by ADD/SUB and cleared by AND/OR/XOR.
  - MOV, LDI and NOP leave `carry` unchanged.
  - NOP leaves `result` and `zero` unchanged.
- rd equal to rs1/rs2, and rs1 == rs2, are legal. The read happens before the write.
- `done` pulses one cycle for every accepted command, including NOP.

## Timing
- Reset values: all outputs 0, including `cmd_ready`. State is IDLE.
- `cmd_ready` is registered. It goes 1 on the first rising edge after `reset` deasserts. It is 1 exactly while in IDLE.
- The accept edge is T.
  - MOV/ALU: READ in cycle T+1, EXEC in T+2, WRITE in T+3 (the register file writes on the edge ending T+3). `done` is high in T+4, together with `cmd_ready`=1.
  - LDI: WRITE in T+1, `done` in T+2.
  - NOP: `done` in T+1, no write.
- `result`/`flags` update on the edge ending EXEC (ALU/MOV) or the accept edge (LDI). They are valid no later than WRITE.
- Back-to-back: a command presented during the `done` cycle is accepted on that cycle's edge. There is no bubble beyond the IDLE cycle.
- Reset mid-operation: asserting `reset` forces state IDLE and all outputs to 0 immediately (`RE` drops asynchronously). The in-flight command is dropped, there is no write, and no `done` pulse is produced.

## Structure
- Shared package `rf_seq_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_XOR`)
  - state encoding (`S_IDLE`, `S_READ`, `S_EXEC`, `S_WRITE`)
  - WIDTH/AW defaults
- One sub-module, `rf_seq_alu`: combinational op, a, b, imm -> result, carry_out, carry_update.
- The FSM, the command latch and the flag registers stay in `rf_op_sequencer`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles -> all outputs 0; release -> `cmd_ready`=1 after the first edge; `busy`=0.
- **LDI:** LDI r1,0011 then LDI r2,1101 -> each has one WRITE cycle (`RE`=1, `WR`=01, `WRD`=0011, then `WR`=10, `WRD`=1101); `done` at T+2; `zero`=0.
- **ADD:** ADD r3,r1,r2 -> `RA`=01 and `RB`=10 during READ/EXEC; `WRD`=0000 and `WR`=11 in T+3; `carry`=1, `zero`=1; `done` at T+4.
- **SUB:** SUB r0,r1,r2 -> `WRD`=0110, `carry`=1. Then XOR r0,r1,r1 -> `WRD`=0000, `zero`=1, `carry`=0.
- **Back-to-back:** hold `cmd_valid`=1 for two commands while toggling `cmd_*` after accept -> `cmd_ready`=0 through READ/EXEC/WRITE; the second accept lands on the `done` cycle; latched fields are unaffected by the toggling.
- **Reset mid-operation:** ADD r0,r1,r2 with `reset`=0 during EXEC -> `RE` never 1, r0 is unchanged on readback, no `done` pulse, state IDLE, flags 0.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file operation sequencer.
// Holds the opcode encodings, the FSM state encoding and the default
// data/address widths used by rf_op_sequencer and rf_seq_alu.
package rf_seq_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned AW_DEF    = 2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the register-file sequencer.
// Ports:
//   op_i           opcode (see rf_seq_pkg)
//   a_i, b_i       operand values read from the register file
//   imm_i          immediate (LDI)
//   result_o       WIDTH-bit wrap-around result
//   carry_out_o    ADD carry / SUB borrow; 0 for logic ops
//   carry_update_o high when the op is allowed to change the carry flag
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o,
    output logic             carry_update_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Extended subtraction: the top bit is set exactly when a < b (unsigned).
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o       = '0;
        carry_out_o    = 1'b0;
        carry_update_o = 1'b0;
        unique case (op_i)
            OP_NOP: result_o = '0;
            OP_LDI: result_o = imm_i;
            OP_MOV: result_o = a_i;
            OP_ADD: begin
                result_o       = sum[WIDTH-1:0];
                carry_out_o    = sum[WIDTH];
                carry_update_o = 1'b1;
            end
            OP_SUB: begin
                result_o       = diff[WIDTH-1:0];
                carry_out_o    = diff[WIDTH];
                carry_update_o = 1'b1;
            end
            OP_AND: begin
                result_o       = a_i & b_i;
                carry_update_o = 1'b1;
            end
            OP_OR: begin
                result_o       = a_i | b_i;
                carry_update_o = 1'b1;
            end
            OP_XOR: begin
                result_o       = a_i ^ b_i;
                carry_update_o = 1'b1;
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Micro-sequencer executing one register-file operation per command.
// Accepts a command over valid/ready, reads rs1/rs2 from the register file,
// computes in rf_seq_alu, writes rd back and pulses done with result/flags.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake (ready registered, high in IDLE)
//   cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i  command fields
//   ra_o, rb_o, a_i, b_i    register-file read ports (address out, data in)
//   re_o, wr_o, wrd_o       register-file write enable/address/data
//   done_o                  one-cycle completion pulse
//   result_o, zero_o, carry_o  last result and flags (held)
//   busy_o                  command in flight
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [AW-1:0]    cmd_rd_i,
    input  logic [AW-1:0]    cmd_rs1_i,
    input  logic [AW-1:0]    cmd_rs2_i,
    input  logic [WIDTH-1:0] cmd_imm_i,
    output logic [AW-1:0]    ra_o,
    output logic [AW-1:0]    rb_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             re_o,
    output logic [AW-1:0]    wr_o,
    output logic [WIDTH-1:0] wrd_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    rs1_q, rs1_d;
    logic [AW-1:0]    rs2_q, rs2_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_carry_upd;

    rf_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i           (op_q),
        .a_i            (a_i),
        .b_i            (b_i),
        .imm_i          (imm_q),
        .result_o       (alu_result),
        .carry_out_o    (alu_carry),
        .carry_update_o (alu_carry_upd)
    );

    // ready_q is only ever high in IDLE, so it alone qualifies the accept.
    assign accept = cmd_valid_i & ready_q;

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;

        if (accept) begin
            op_d  = cmd_op_i;
            rd_d  = cmd_rd_i;
            rs1_d = cmd_rs1_i;
            rs2_d = cmd_rs2_i;
            imm_d = cmd_imm_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op_i == OP_NOP) begin
                        // NOP completes immediately without touching flags.
                        done_d = 1'b1;
                    end else if (cmd_op_i == OP_LDI) begin
                        // LDI needs no read, so its result is taken at accept.
                        state_d  = S_WRITE;
                        result_d = cmd_imm_i;
                        zero_d   = (cmd_imm_i == '0);
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                // Read data sampled here covers both combinational and
                // one-cycle registered register-file reads.
                state_d  = S_WRITE;
                result_d = alu_result;
                zero_d   = (alu_result == '0);
                if (alu_carry_upd) begin
                    carry_d = alu_carry;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= OP_NOP;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Outputs decode directly from state_q so reset clears them at once.
    always_comb begin
        ra_o  = '0;
        rb_o  = '0;
        re_o  = 1'b0;
        wr_o  = '0;
        wrd_o = '0;
        if (state_q == S_READ || state_q == S_EXEC) begin
            ra_o = rs1_q;
            rb_o = rs2_q;
        end
        if (state_q == S_WRITE) begin
            re_o  = 1'b1;
            wr_o  = rd_q;
            wrd_o = result_q;
        end
    end

    assign cmd_ready_o = ready_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign carry_o     = carry_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer: a register-file fixture answers the
// read ports, a program-order model predicts each command's write, flags and
// completion time, and a negedge monitor compares against the queued results.
module tb_rf_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [3:0] cmd_imm;
    logic [1:0] ra, rb, wr;
    logic [3:0] a, b, wrd, result;
    logic       re, done, zero, carry, busy;

    always #5 clk = ~clk;

    rf_op_sequencer #(
        .WIDTH (4),
        .AW    (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_rd_i    (cmd_rd),
        .cmd_rs1_i   (cmd_rs1),
        .cmd_rs2_i   (cmd_rs2),
        .cmd_imm_i   (cmd_imm),
        .ra_o        (ra),
        .rb_o        (rb),
        .a_i         (a),
        .b_i         (b),
        .re_o        (re),
        .wr_o        (wr),
        .wrd_o       (wrd),
        .done_o      (done),
        .result_o    (result),
        .zero_o      (zero),
        .carry_o     (carry),
        .busy_o      (busy)
    );

    // Register-file fixture: combinational reads, write on the clock edge.
    logic [3:0] rf [4];
    logic [3:0] rf_init [4];
    logic       rf_load;
    assign a = rf[ra];
    assign b = rf[rb];
    always @(posedge clk) begin
        if (rf_load) rf <= rf_init;
        else if (re) rf[wr] <= wrd;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state, updated in command order at accept time.
    typedef struct {
        int         edge_n;
        int         lat;
        logic [3:0] res;
        logic       z;
        logic       c;
    } done_t;
    typedef struct {
        int         cyc_n;
        logic [1:0] rd;
        logic [3:0] d;
    } wr_t;

    done_t      dq[$];
    wr_t        wq[$];
    logic [3:0] mr [4];
    logic [3:0] m_res;
    logic       m_z, m_c;
    int         free_cyc;
    bit         mon_en = 1'b0;

    task automatic model_accept();
        int         t;
        int         lat;
        int         av, bv, r;
        done_t      de;
        wr_t        we;
        t  = cyc + 1;
        av = int'(mr[cmd_rs1]);
        bv = int'(mr[cmd_rs2]);
        r  = 0;
        case (cmd_op)
            3'd0: lat = 0;
            3'd1: begin lat = 1; r = int'(cmd_imm); end
            3'd2: begin lat = 3; r = av; end
            3'd3: begin lat = 3; r = (av + bv) % 16; m_c = ((av + bv) > 15); end
            3'd4: begin lat = 3; r = (av - bv + 16) % 16; m_c = (av < bv); end
            3'd5: begin lat = 3; r = av & bv; m_c = 1'b0; end
            3'd6: begin lat = 3; r = av | bv; m_c = 1'b0; end
            default: begin lat = 3; r = av ^ bv; m_c = 1'b0; end
        endcase
        if (cmd_op != 3'd0) begin
            m_res       = 4'(r);
            m_z         = (r == 0);
            mr[cmd_rd]  = 4'(r);
            we.cyc_n    = t + lat - 1;
            we.rd       = cmd_rd;
            we.d        = 4'(r);
            wq.push_back(we);
        end
        de.edge_n = t;
        de.lat    = lat;
        de.res    = m_res;
        de.z      = m_z;
        de.c      = m_c;
        dq.push_back(de);
        free_cyc = t + lat;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            done_t de;
            wr_t   we;
            check_eq("cmd_ready", int'(cmd_ready), int'(cyc >= free_cyc));
            check_eq("busy", int'(busy), int'(!cmd_ready));
            if (done) begin
                if (dq.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    de = dq.pop_front();
                    check_eq("done_cycle", cyc, de.edge_n + de.lat);
                    check_eq("result", int'(result), int'(de.res));
                    check_eq("zero", int'(zero), int'(de.z));
                    check_eq("carry", int'(carry), int'(de.c));
                end
            end
            if (re) begin
                if (wq.size() == 0) begin
                    check_eq("unexpected_write", 1, 0);
                end else begin
                    we = wq.pop_front();
                    check_eq("write_cycle", cyc, we.cyc_n);
                    check_eq("wr", int'(wr), int'(we.rd));
                    check_eq("wrd", int'(wrd), int'(we.d));
                end
            end else begin
                check_eq("idle_wr_wrd", int'({wr, wrd}), 0);
            end
            if (cmd_valid && cmd_ready) model_accept();
        end
    end

    task automatic randomize_fields();
        cmd_op  = 3'($urandom);
        cmd_rd  = 2'($urandom);
        cmd_rs1 = 2'($urandom);
        cmd_rs2 = 2'($urandom);
        cmd_imm = 4'($urandom);
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] imm);
        bit got;
        @(posedge clk);
        #1;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        if (!got) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        randomize_fields();  // later changes must not disturb the latched command
    endtask

    bit         watch = 1'b0;
    bit         seen_re, seen_done;
    logic [3:0] r0_before;
    always @(posedge clk) begin
        if (watch) begin
            if (re) seen_re <= 1'b1;
            if (done) seen_done <= 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit drained;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
        rf_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rf_init[i] = 4'($urandom);
            mr[i]      = rf_init[i];
        end
        m_res = '0; m_z = 1'b0; m_c = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs",
                 int'({cmd_ready, busy, done, re, wr, wrd, ra, rb, result, zero, carry}), 0);
        rf_load = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_reset", int'(cmd_ready), 1);
        check_eq("busy_after_reset", int'(busy), 0);
        free_cyc = cyc;
        mon_en = 1'b1;

        send(3'd1, 2'd1, 2'd0, 2'd0, 4'b0011);   // LDI r1,3
        send(3'd1, 2'd2, 2'd0, 2'd0, 4'b1101);   // LDI r2,13
        send(3'd3, 2'd3, 2'd1, 2'd2, 4'd0);      // ADD r3,r1,r2 -> 0, carry
        send(3'd4, 2'd0, 2'd1, 2'd2, 4'd0);      // SUB r0,r1,r2 -> 6, borrow
        send(3'd7, 2'd0, 2'd1, 2'd1, 4'd0);      // XOR r0,r1,r1 -> 0
        send(3'd2, 2'd2, 2'd3, 2'd0, 4'd0);      // MOV r2,r3
        send(3'd0, 2'd0, 2'd0, 2'd0, 4'd0);      // NOP
        send(3'd3, 2'd1, 2'd1, 2'd1, 4'd0);      // ADD r1,r1,r1 (rd == rs)

        // Random traffic: valid mostly high and fields changing every cycle.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = (($urandom % 4) != 0);
            randomize_fields();
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;

        drained = 1'b0;
        for (int i = 0; i < 30 && !drained; i++) begin
            @(negedge clk);
            if (dq.size() == 0 && wq.size() == 0) drained = 1'b1;
        end
        check_eq("drain", int'(drained), 1);
        for (int i = 0; i < 4; i++) check_eq("regfile", int'(rf[i]), int'(mr[i]));

        // Reset in the middle of an ADD: no write, no done, outputs cleared.
        mon_en    = 1'b0;
        r0_before = rf[0];
        seen_re   = 1'b0;
        seen_done = 1'b0;
        @(posedge clk);
        #1;
        cmd_op = 3'd3; cmd_rd = 2'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2;
        cmd_valid = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready", int'(cmd_ready), 1);
        watch = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("exec_ra", int'(ra), 1);
        check_eq("exec_rb", int'(rb), 2);
        check_eq("exec_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs",
                 int'({cmd_ready, busy, done, re, wr, wrd, ra, rb, result, zero, carry}), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        watch = 1'b0;
        check_eq("midrst_no_write", int'(seen_re), 0);
        check_eq("midrst_no_done", int'(seen_done), 0);
        check_eq("midrst_r0_kept", int'(rf[0]), int'(r0_before));
        check_eq("midrst_flags", int'({result, zero, carry}), 0);
        check_eq("midrst_idle", int'({cmd_ready, busy}), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
